uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin packet arbiter and configuration sequencer in front of the UART transmitter.
- Shares the single TX FIFO write port among N_REQ requesters, one whole packet at a time.
- Serialises host configuration requests: drains the transmitter, drives config_req_mst, waits for req_done, then resumes arbitration.
- Transmitter must run with tx_data_stream_mode = 1, so tx_done pulses only when its FIFO is empty.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16. IW = $clog2(N_REQ).
- STALL_LIMIT, 1024, watchdog idle-cycle limit (used only with the optional feature); must be ≥ 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  N_REQ  per-requester byte valid.
- req_data_i  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  N_REQ  marks the last byte of a packet.
- req_ready_o  out  N_REQ  per-requester accept.
- grant_id_o  out  IW  requester currently owning the FIFO.
- grant_vld_o  out  1  a packet is in progress.
- cfg_req_i  in  1  host configuration request, pulse or level.
- cfg_done_o  out  1  one-cycle pulse when the configuration request has completed.
- tx_data_o  out  8  to the transmitter data_tx.
- tx_fifo_write_o  out  1  to the transmitter tx_fifo_write.
- tx_fifo_full_i  in  1  from the transmitter.
- tx_fifo_empty_i  in  1  from the transmitter.
- tx_done_i  in  1  from the transmitter.
- config_req_mst_o  out  1  to the transmitter config_req_mst.
- req_done_i  in  1  from the transmitter.
- abort_o  out  1  watchdog abort pulse; tied 0 when the feature is disabled.

Behaviour:
- Reset values: all outputs 0 (grant_id_o = 0, req_ready_o = 0, config_req_mst_o = 0). Round-robin pointer = N_REQ-1, so requester 0 has first priority. cfg_pending = 0, tx_pending = 0, state = IDLE.
- cfg_pending is set by cfg_req_i in any state. It is cleared on entry to CFG_REQ.
- tx_pending is set on every tx_fifo_write_o. It is cleared when tx_done_i && tx_fifo_empty_i && !tx_fifo_write_o.
- States: IDLE, XFER, CFG_DRAIN, CFG_REQ.
- IDLE:
  - If cfg_pending (or cfg_req_i this cycle), go to CFG_DRAIN. Configuration beats arbitration when both arrive in the same cycle.
  - Else, if any req_valid_i is set, pick the first valid index after the pointer (wrapping modulo N_REQ). Register it in grant_id_o, set grant_vld_o, go to XFER.
  - Grant takes effect the next cycle, i.e. one cycle of arbitration latency.
- XFER:
  - req_ready_o[g] = !tx_fifo_full_i. All other ready bits are 0.
  - tx_fifo_write_o = req_valid_i[g] && req_ready_o[g], combinational. tx_data_o = byte g, always muxed.
  - An accepted beat with req_last_i[g] set returns to IDLE next cycle. It also sets pointer = g and clears grant_vld_o.
  - A cfg_req_i arriving mid-packet does not interrupt the packet.
  - A full FIFO stalls the packet: ready is 0 and no write is issued.
- CFG_DRAIN: no ready asserted. Wait for !tx_pending && tx_fifo_empty_i, then go to CFG_REQ.
- CFG_REQ:
  - config_req_mst_o = 1, decoded from the state register.
  - On req_done_i, go to IDLE. config_req_mst_o is therefore 0 the following cycle, which satisfies the transmitter's deassert rule.
  - cfg_done_o pulses in that following cycle.
- Single-byte packet (valid and last together on the first beat): 1 write, then IDLE. Minimum packet period is 2 cycles per packet.
- Reset mid-operation: the state machine returns to IDLE immediately. A byte already written to the FIFO is not recalled. config_req_mst_o drops in the cycle after rst_i is sampled.
- Requester obligation: after raising valid, hold data and last stable until ready. Not checked by this block.

Optional Feature:
- Macro: UART_TX_SCHED_WATCHDOG_EN.
- Enabled:
  - In XFER, a stall counter (width $clog2(STALL_LIMIT+1)) increments on every cycle where req_valid_i[g] = 0. It clears on every accepted beat and on entry to XFER. FIFO-full cycles are not counted.
  - When the counter reaches STALL_LIMIT: abort_o pulses 1 cycle, grant_id_o holds the aborted id for that cycle, pointer = g, then go to IDLE.
  - A partial packet remains in the FIFO. It is the host's responsibility.
- Disabled: no counter. XFER waits indefinitely for last. abort_o is a constant 0.

Test Plan:
- Requesters 0 and 2 both valid from reset, each with a 3-byte packet (0xA1,0xA2,0xA3 / 0xC1,0xC2,0xC3) -> FIFO receives A1 A2 A3 then C1 C2 C3. grant_id_o is 0 then 2. Exactly 6 write pulses.
- All 4 requesters continuously sending 1-byte packets -> grant order 0,1,2,3,0. One write every 2 cycles.
- tx_fifo_full_i held 1 for 5 cycles mid-packet -> no writes and req_ready_o = 0 during those cycles. The packet resumes intact.
- cfg_req_i pulsed during byte 2 of a 4-byte packet from requester 1 ->
  - all 4 bytes are written;
  - config_req_mst_o stays 0 until tx_done_i && tx_fifo_empty_i;
  - config_req_mst_o then rises; req_done_i → config_req_mst_o = 0 and cfg_done_o = 1 on the next cycle;
  - no grant is issued in between.
- cfg_req_i and req_valid_i[3] asserted in the same IDLE cycle -> configuration runs first; requester 3 is granted in the cycle after cfg_done_o.
- With UART_TX_SCHED_WATCHDOG_EN and STALL_LIMIT = 8: requester 2 sends 1 byte without last, then drops valid -> abort_o pulses after exactly 8 idle cycles with grant_id_o = 2. Next grant goes to requester 3 if valid.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet arbiter and configuration sequencer in front of a UART TX FIFO.
// Define UART_TX_SCHED_WATCHDOG_EN to enable the stalled-requester watchdog (abort_o).
`timescale 1ns/1ps
module uart_tx_scheduler #(
   parameter int  N_REQ       = 4,
   parameter int  STALL_LIMIT = 1024,
   localparam int IW          = $clog2(N_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_REQ-1:0]   req_valid_i,
   input  logic [8*N_REQ-1:0] req_data_i,
   input  logic [N_REQ-1:0]   req_last_i,
   output logic [N_REQ-1:0]   req_ready_o,
   output logic [IW-1:0]      grant_id_o,
   output logic               grant_vld_o,
   input  logic               cfg_req_i,
   output logic               cfg_done_o,
   output logic [7:0]         tx_data_o,
   output logic               tx_fifo_write_o,
   input  logic               tx_fifo_full_i,
   input  logic               tx_fifo_empty_i,
   input  logic               tx_done_i,
   output logic               config_req_mst_o,
   input  logic               req_done_i,
   output logic               abort_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_CFG_DRAIN,
      S_CFG_REQ
   } state_t;

   if (N_REQ < 2 || N_REQ > 16 || STALL_LIMIT < 2) begin : g_param_check
      $error("uart_tx_scheduler: N_REQ must be 2..16 and STALL_LIMIT >= 2");
   end

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q;
   logic            cfg_pending_q;
   logic            tx_pending_q;
   logic [IW-1:0]   arb_id;
   logic            arb_found;
   logic            g_valid;
   logic            g_last;
   logic            stall_hit;

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return IW'(sum);
   endfunction

   // Search starts just after the last owner, so the previous winner has lowest priority.
   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!arb_found && req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
            arb_found = 1'b1;
            arb_id    = wrap_idx(rr_ptr_q, i);
         end
      end
   end

   always_comb begin
      g_valid   = 1'b0;
      g_last    = 1'b0;
      tx_data_o = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_id_o == IW'(k)) begin
            g_valid   = req_valid_i[k];
            g_last    = req_last_i[k];
            tx_data_o = req_data_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
      state_d          = state_q;
      req_ready_o      = '0;
      tx_fifo_write_o  = 1'b0;
      config_req_mst_o = 1'b0;
      abort_o          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_pending_q || cfg_req_i) state_d = S_CFG_DRAIN;
            else if (arb_found)             state_d = S_XFER;
         end
         S_XFER: begin
            if (stall_hit) begin
               abort_o = 1'b1;
               state_d = S_IDLE;
            end else begin
               req_ready_o[grant_id_o] = !tx_fifo_full_i;
               tx_fifo_write_o         = g_valid && !tx_fifo_full_i;
               if (tx_fifo_write_o && g_last) state_d = S_IDLE;
            end
         end
         S_CFG_DRAIN: begin
            if (!tx_pending_q && tx_fifo_empty_i) state_d = S_CFG_REQ;
         end
         S_CFG_REQ: begin
            config_req_mst_o = 1'b1;
            if (req_done_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx_pending covers bytes still in flight after the FIFO reports empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_id_o    <= '0;
         grant_vld_o   <= 1'b0;
         rr_ptr_q      <= IW'(N_REQ - 1);
         cfg_pending_q <= 1'b0;
         tx_pending_q  <= 1'b0;
         cfg_done_o    <= 1'b0;
      end else begin
         cfg_done_o <= (state_q == S_CFG_REQ) && req_done_i;

         if (state_q == S_CFG_DRAIN && state_d == S_CFG_REQ) cfg_pending_q <= 1'b0;
         else if (cfg_req_i)                                 cfg_pending_q <= 1'b1;

         if (tx_fifo_write_o)                    tx_pending_q <= 1'b1;
         else if (tx_done_i && tx_fifo_empty_i)  tx_pending_q <= 1'b0;

         if (state_q == S_IDLE && state_d == S_XFER) begin
            grant_id_o  <= arb_id;
            grant_vld_o <= 1'b1;
         end
         // Leaving XFER happens only on a last beat or an abort; both hand priority onward.
         if (state_q == S_XFER && state_d == S_IDLE) begin
            rr_ptr_q    <= grant_id_o;
            grant_vld_o <= 1'b0;
         end
      end
   end

`ifdef UART_TX_SCHED_WATCHDOG_EN
   localparam int SW = $clog2(STALL_LIMIT + 1);
   logic [SW-1:0] stall_cnt_q;

   assign stall_hit = (state_q == S_XFER) && (stall_cnt_q == SW'(STALL_LIMIT));

   // Only cycles where the owner has nothing to offer count; FIFO back-pressure does not.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_q <= '0;
      else if (state_q != S_XFER || tx_fifo_write_o)
         stall_cnt_q <= '0;
      else if (!g_valid && !tx_fifo_full_i && !stall_hit)
         stall_cnt_q <= stall_cnt_q + 1'b1;
   end
`else
   assign stall_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table-driven arbitration vectors plus hand-written
// sequences for FIFO stall, configuration drain/handshake, reset and the optional watchdog.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

   localparam int N = 4;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic [N-1:0]   req_valid_i = '0;
   logic [8*N-1:0] req_data_i  = '0;
   logic [N-1:0]   req_last_i  = '0;
   logic [N-1:0]   req_ready_o;
   logic [1:0]     grant_id_o;
   logic           grant_vld_o;
   logic           cfg_req_i = 1'b0;
   logic           cfg_done_o;
   logic [7:0]     tx_data_o;
   logic           tx_fifo_write_o;
   logic           tx_fifo_full_i  = 1'b0;
   logic           tx_fifo_empty_i = 1'b1;
   logic           tx_done_i       = 1'b0;
   logic           config_req_mst_o;
   logic           req_done_i = 1'b0;
   logic           abort_o;

   uart_tx_scheduler #(.N_REQ(N), .STALL_LIMIT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
      .req_ready_o(req_ready_o), .grant_id_o(grant_id_o), .grant_vld_o(grant_vld_o),
      .cfg_req_i(cfg_req_i), .cfg_done_o(cfg_done_o),
      .tx_data_o(tx_data_o), .tx_fifo_write_o(tx_fifo_write_o),
      .tx_fifo_full_i(tx_fifo_full_i), .tx_fifo_empty_i(tx_fifo_empty_i), .tx_done_i(tx_done_i),
      .config_req_mst_o(config_req_mst_o), .req_done_i(req_done_i), .abort_o(abort_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass  = 0;
   int n_total = 0;

   // Requester model: per-requester packet byte store {last, data}, popped on valid&ready.
   logic [8:0] pkt_mem [N][32];
   int         head [N] = '{default: 0};
   int         tail [N] = '{default: 0};

   // Write log captured just before each active edge.
   logic [7:0] wr_data [64];
   logic [1:0] wr_gid  [64];
   int         wr_cyc  [64];
   int         wr_cnt    = 0;
   int         cyc_cnt   = 0;
   int         abort_cnt = 0;

   typedef struct {
      logic [3:0]      mask;
      int              n;
      logic [3:0][1:0] order;
   } arb_vec_t;

   arb_vec_t vecs [5];

   function automatic logic [3:0][1:0] ord(input logic [1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input int k, input logic [7:0] d, input logic l);
      if (tail[k] < 32) begin
         pkt_mem[k][tail[k]] = {l, d};
         tail[k]++;
      end
   endtask

   task automatic wait_writes(input int n, input int budget, input string name);
      int i = 0;
      while (wr_cnt < n && i < budget) begin
         @(negedge clk_i);
         i++;
      end
      check(name, 32'(wr_cnt >= n), 1);
   endtask

   task automatic wait_cfg_mst(input int budget, input string name);
      int i = 0;
      while (config_req_mst_o !== 1'b1 && i < budget) begin
         @(negedge clk_i);
         #2;
         i++;
      end
      check(name, 32'(config_req_mst_o), 1);
   endtask

   task automatic reset_on();
      @(negedge clk_i);
      rst_i           = 1'b1;
      cfg_req_i       = 1'b0;
      req_done_i      = 1'b0;
      tx_fifo_full_i  = 1'b0;
      tx_fifo_empty_i = 1'b1;
      tx_done_i       = 1'b0;
      for (int k = 0; k < N; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
      @(negedge clk_i);
      @(negedge clk_i);
      wr_cnt = 0;
   endtask

   always begin
      @(negedge clk_i);
      #1;
      for (int k = 0; k < N; k++) begin
         if (head[k] < tail[k]) begin
            req_valid_i[k]       = 1'b1;
            req_data_i[8*k +: 8] = pkt_mem[k][head[k]][7:0];
            req_last_i[k]        = pkt_mem[k][head[k]][8];
         end else begin
            req_valid_i[k]       = 1'b0;
            req_data_i[8*k +: 8] = 8'h00;
            req_last_i[k]        = 1'b0;
         end
      end
   end

   always begin
      @(negedge clk_i);
      #4;
      cyc_cnt++;
      if (tx_fifo_write_o && wr_cnt < 64) begin
         wr_data[wr_cnt] = tx_data_o;
         wr_gid[wr_cnt]  = grant_id_o;
         wr_cyc[wr_cnt]  = cyc_cnt;
         wr_cnt++;
      end
      for (int k = 0; k < N; k++)
         if (req_valid_i[k] && req_ready_o[k]) head[k]++;
      if (abort_o) abort_cnt++;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] t1_data [6];
      t1_data = '{8'hA1, 8'hA2, 8'hA3, 8'hC1, 8'hC2, 8'hC3};

      vecs[0] = '{mask: 4'b1010, n: 2, order: ord(2'd1, 2'd3, 2'd0, 2'd0)};
      vecs[1] = '{mask: 4'b0110, n: 2, order: ord(2'd1, 2'd2, 2'd0, 2'd0)};
      vecs[2] = '{mask: 4'b1001, n: 2, order: ord(2'd3, 2'd0, 2'd0, 2'd0)};
      vecs[3] = '{mask: 4'b0001, n: 1, order: ord(2'd0, 2'd0, 2'd0, 2'd0)};
      vecs[4] = '{mask: 4'b1111, n: 4, order: ord(2'd1, 2'd2, 2'd3, 2'd0)};

      // Reset values, with requesters 0 and 2 already presenting packets.
      reset_on();
      push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
      push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1);
      @(negedge clk_i);
      #2;
      check("rst_ready",   32'(req_ready_o), 0);
      check("rst_gid",     32'(grant_id_o), 0);
      check("rst_gvld",    32'(grant_vld_o), 0);
      check("rst_write",   32'(tx_fifo_write_o), 0);
      check("rst_cfg_mst", 32'(config_req_mst_o), 0);
      check("rst_cfg_done", 32'(cfg_done_o), 0);
      check("rst_abort",   32'(abort_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      wait_writes(6, 40, "t1_done");
      repeat (6) @(negedge clk_i);
      check("t1_write_count", 32'(wr_cnt), 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t1_data%0d", i), 32'(wr_data[i]), 32'(t1_data[i]));
         check($sformatf("t1_gid%0d", i), 32'(wr_gid[i]), (i < 3) ? 0 : 2);
      end

      // Table-driven arbitration rounds of single-byte packets; pointer carries across rows.
      reset_on();
      rst_i = 1'b0;
      for (int v = 0; v < 5; v++) begin
         int base;
         base = wr_cnt;
         @(negedge clk_i);
         for (int k = 0; k < N; k++)
            if (vecs[v].mask[k]) push(k, {4'(k), 4'(v)}, 1'b1);
         wait_writes(base + vecs[v].n, 40, $sformatf("arb%0d_done", v));
         for (int j = 0; j < vecs[v].n; j++) begin
            check($sformatf("arb%0d_gid%0d", v, j), 32'(wr_gid[base+j]), 32'(vecs[v].order[j]));
            check($sformatf("arb%0d_src%0d", v, j), 32'(wr_data[base+j][7:4]), 32'(vecs[v].order[j]));
         end
      end

      // All four requesters streaming 1-byte packets: strict rotation, one write per 2 cycles.
      reset_on();
      for (int k = 0; k < N; k++) begin
         push(k, {4'(k), 4'h1}, 1'b1);
         push(k, {4'(k), 4'h2}, 1'b1);
      end
      rst_i = 1'b0;
      wait_writes(8, 60, "rr_done");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rr_gid%0d", i), 32'(wr_gid[i]), 32'(i % 4));
         if (i > 0) check($sformatf("rr_period%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 2);
      end

      // FIFO full for 5 cycles mid-packet.
      reset_on();
      push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b0); push(1, 8'h14, 1'b1);
      rst_i = 1'b0;
      wait_writes(1, 20, "full_first");
      tx_fifo_full_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         check($sformatf("full_nowrite%0d", i), 32'(tx_fifo_write_o), 0);
         check($sformatf("full_noready%0d", i), 32'(req_ready_o), 0);
         @(negedge clk_i);
      end
      tx_fifo_full_i = 1'b0;
      wait_writes(4, 20, "full_done");
      for (int i = 0; i < 4; i++)
         check($sformatf("full_data%0d", i), 32'(wr_data[i]), 32'(8'h11 + i));
      check("full_resume_gap", 32'(wr_cyc[1] - wr_cyc[0]), 6);

      // Config request during byte 2 of a 4-byte packet; requester 0 waits behind it.
      reset_on();
      rst_i = 1'b0;
      tx_fifo_empty_i = 1'b0;
      push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b0); push(1, 8'h24, 1'b1);
      wait_writes(1, 20, "cfgmid_first");
      cfg_req_i = 1'b1;
      push(0, 8'h0F, 1'b1);
      @(negedge clk_i);
      cfg_req_i = 1'b0;
      wait_writes(4, 20, "cfgmid_pkt_done");
      for (int i = 0; i < 4; i++)
         check($sformatf("cfgmid_data%0d", i), 32'(wr_data[i]), 32'(8'h21 + i));
      for (int i = 0; i < 3; i++) begin
         #2;
         check($sformatf("cfgmid_drain_mst%0d", i), 32'(config_req_mst_o), 0);
         check($sformatf("cfgmid_drain_nogrant%0d", i), 32'(grant_vld_o), 0);
         @(negedge clk_i);
      end
      tx_done_i       = 1'b1;
      tx_fifo_empty_i = 1'b1;
      #2;
      check("cfgmid_mst_at_done", 32'(config_req_mst_o), 0);
      @(negedge clk_i);
      tx_done_i = 1'b0;
      #2;
      check("cfgmid_mst_after_done", 32'(config_req_mst_o), 0);
      @(negedge clk_i);
      #2;
      check("cfgmid_mst_rise", 32'(config_req_mst_o), 1);
      check("cfgmid_req_nogrant", 32'(grant_vld_o), 0);
      @(negedge clk_i);
      req_done_i = 1'b1;
      #2;
      check("cfgmid_done_not_early", 32'(cfg_done_o), 0);
      @(negedge clk_i);
      req_done_i = 1'b0;
      #2;
      check("cfgmid_mst_fall", 32'(config_req_mst_o), 0);
      check("cfgmid_cfg_done", 32'(cfg_done_o), 1);
      @(negedge clk_i);
      #2;
      check("cfgmid_cfg_done_pulse", 32'(cfg_done_o), 0);
      check("cfgmid_regrant_vld", 32'(grant_vld_o), 1);
      check("cfgmid_regrant_id", 32'(grant_id_o), 0);
      wait_writes(5, 10, "cfgmid_req0_write");
      check("cfgmid_req0_data", 32'(wr_data[4]), 32'h0F);

      // Config and requester 3 in the same IDLE cycle: config wins.
      reset_on();
      rst_i = 1'b0;
      @(negedge clk_i);
      push(3, 8'h3F, 1'b1);
      cfg_req_i = 1'b1;
      @(negedge clk_i);
      cfg_req_i = 1'b0;
      #2;
      check("tie_no_grant", 32'(grant_vld_o), 0);
      wait_cfg_mst(10, "tie_mst_rise");
      @(negedge clk_i);
      req_done_i = 1'b1;
      @(negedge clk_i);
      req_done_i = 1'b0;
      #2;
      check("tie_cfg_done", 32'(cfg_done_o), 1);
      check("tie_still_no_grant", 32'(grant_vld_o), 0);
      @(negedge clk_i);
      #2;
      check("tie_grant_vld", 32'(grant_vld_o), 1);
      check("tie_grant_id", 32'(grant_id_o), 3);
      wait_writes(1, 10, "tie_write");
      check("tie_data", 32'(wr_data[0]), 32'h3F);

      // Reset while config_req_mst_o is high: it drops in the cycle after rst_i is sampled.
      @(negedge clk_i);
      cfg_req_i = 1'b1;
      tx_done_i = 1'b1;
      @(negedge clk_i);
      cfg_req_i = 1'b0;
      tx_done_i = 1'b0;
      #2;
      wait_cfg_mst(10, "rstmid_mst_rise");
      @(negedge clk_i);
      rst_i = 1'b1;
      #2;
      check("rstmid_mst_before", 32'(config_req_mst_o), 1);
      @(negedge clk_i);
      #2;
      check("rstmid_mst_after", 32'(config_req_mst_o), 0);
      check("rstmid_gvld", 32'(grant_vld_o), 0);

      // Stalled owner: requester 2 sends one byte without last, then goes quiet.
      reset_on();
      push(2, 8'h2E, 1'b0);
      push(3, 8'h3E, 1'b1);
      rst_i = 1'b0;
      wait_writes(1, 20, "wd_first");
      check("wd_first_data", 32'(wr_data[0]), 32'h2E);
`ifdef UART_TX_SCHED_WATCHDOG_EN
      for (int i = 1; i <= 8; i++) begin
         #2;
         check($sformatf("wd_quiet%0d", i), 32'(abort_o), 0);
         @(negedge clk_i);
      end
      #2;
      check("wd_abort", 32'(abort_o), 1);
      check("wd_abort_gid", 32'(grant_id_o), 2);
      @(negedge clk_i);
      #2;
      check("wd_abort_pulse", 32'(abort_o), 0);
      @(negedge clk_i);
      #2;
      check("wd_next_vld", 32'(grant_vld_o), 1);
      check("wd_next_id", 32'(grant_id_o), 3);
`else
      repeat (12) @(negedge clk_i);
      #2;
      check("nowd_still_owned", 32'(grant_vld_o), 1);
      check("nowd_owner", 32'(grant_id_o), 2);
      check("nowd_no_abort", 32'(abort_cnt), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
